// File: rtl/ariane_pkg.sv
// Shared LSU types: the FIFO entry format, functional-unit encoding and the
// dispatch FSM state enum used by lsu_dispatch.
package ariane_pkg;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, AMO, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] vaddr;
    logic        overflow;
    logic [63:0] data;
    logic [7:0]  be;
    fu_t         fu;
    logic [2:0]  trans_id;
  } lsu_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HOLD_LD = 2'd1,
    HOLD_ST = 2'd2
  } lsu_dispatch_state_t;

  // Only plain loads take the load path; stores and AMOs go to the store unit.
  function automatic logic is_load(input fu_t fu);
    return fu == LOAD;
  endfunction

endpackage

// File: rtl/lsu_dispatch_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk_i/rst_ni clock and async active-low reset, inc_i count enable,
//        clr_i synchronous clear, q_o current count (sticks at MAX).
module sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX   = 65535
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] MaxVal = MAX[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    q_o <= '0;
    else if (clr_i)                 q_o <= '0;
    else if (inc_i && q_o != MaxVal) q_o <= q_o + 1'b1;
  end

endmodule

// File: rtl/lsu_dispatch.sv
// Drain side of the LSU bypass FIFO. Captures the head entry into a one-entry
// issue register, presents it to the load or store unit, and pops the FIFO
// head in the capture cycle. Also keeps saturating per-class accept counts
// and a stall flag for requests that sit unaccepted too long.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i sync flush;
//        lsu_ctrl_i FIFO head; ld_ready_i/st_ready_i unit handshakes;
//        lsu_ctrl_o held request; ld_valid_o/st_valid_o target select;
//        pop_ld_o/pop_st_o FIFO retire pulses; stall_o long-wait flag;
//        ld_cnt_o/st_cnt_o saturating accept counters.
module lsu_dispatch
  import ariane_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STALL_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  lsu_ctrl_t        lsu_ctrl_i,
  input  logic             ld_ready_i,
  input  logic             st_ready_i,
  output lsu_ctrl_t        lsu_ctrl_o,
  output logic             ld_valid_o,
  output logic             st_valid_o,
  output logic             pop_ld_o,
  output logic             pop_st_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] ld_cnt_o,
  output logic [CNT_W-1:0] st_cnt_o
);

  localparam logic [CNT_W-1:0] StallVal = STALL_CYCLES[CNT_W-1:0];

  lsu_dispatch_state_t state_q, state_d;
  lsu_ctrl_t           issue_q;
  logic [CNT_W-1:0]    wait_q;
  logic                hold_ld, hold_st, accept, capture, in_ld;

  assign hold_ld = (state_q == HOLD_LD);
  assign hold_st = (state_q == HOLD_ST);
  assign accept  = (hold_ld & ld_ready_i) | (hold_st & st_ready_i);
  assign in_ld   = is_load(lsu_ctrl_i.fu);
  // rst_ni gates capture so no pop escapes while reset is held low.
  assign capture = lsu_ctrl_i.valid & ((state_q == EMPTY) | accept) & ~flush_i & rst_ni;

  always_comb begin
    state_d = state_q;
    if (flush_i)      state_d = EMPTY;
    else if (capture) state_d = in_ld ? HOLD_LD : HOLD_ST;
    else if (accept)  state_d = EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i)      issue_q <= '0;
      else if (capture) issue_q <= lsu_ctrl_i;
    end
  end

  assign ld_valid_o = hold_ld;
  assign st_valid_o = hold_st;
  assign pop_ld_o   = capture & in_ld;
  assign pop_st_o   = capture & ~in_ld;

  always_comb begin
    lsu_ctrl_o       = issue_q;
    lsu_ctrl_o.valid = (state_q != EMPTY);
  end

  // Accepts in a flush cycle still count: the unit already took the request.
  sat_counter #(.WIDTH(CNT_W), .MAX((2**CNT_W) - 1)) u_ld_cnt (
    .clk_i (clk_i), .rst_ni(rst_ni),
    .inc_i (accept & hold_ld), .clr_i(1'b0), .q_o(ld_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W), .MAX((2**CNT_W) - 1)) u_st_cnt (
    .clk_i (clk_i), .rst_ni(rst_ni),
    .inc_i (accept & hold_st), .clr_i(1'b0), .q_o(st_cnt_o)
  );

  // Counts consecutive held-not-accepted cycles; sticks at STALL_CYCLES.
  sat_counter #(.WIDTH(CNT_W), .MAX(STALL_CYCLES)) u_wait_cnt (
    .clk_i (clk_i), .rst_ni(rst_ni),
    .inc_i ((hold_ld | hold_st) & ~accept),
    .clr_i (capture | accept | flush_i | (state_q == EMPTY)),
    .q_o   (wait_q)
  );

  // Compare on the registered count, so stall_o is glitch-free.
  assign stall_o = (wait_q == StallVal);

endmodule

// File: tb/tb_lsu_dispatch.sv
module tb_lsu_dispatch;
  import ariane_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      flush;
  lsu_ctrl_t lsu_in;
  logic      ld_ready, st_ready;

  lsu_ctrl_t   lsu_out;
  logic        ld_valid, st_valid, pop_ld, pop_st, stall;
  logic [15:0] ld_cnt, st_cnt;

  lsu_ctrl_t   lsu_out2;
  logic        ld_valid2, st_valid2, pop_ld2, pop_st2, stall2;
  logic [1:0]  ld_cnt2, st_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_ld;
    logic [2:0] tid;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  lsu_dispatch #(.CNT_W(16), .STALL_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lsu_ctrl_i(lsu_in),
    .ld_ready_i(ld_ready), .st_ready_i(st_ready), .lsu_ctrl_o(lsu_out),
    .ld_valid_o(ld_valid), .st_valid_o(st_valid), .pop_ld_o(pop_ld),
    .pop_st_o(pop_st), .stall_o(stall), .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
  );

  // Narrow-counter instance for the saturation boundary.
  lsu_dispatch #(.CNT_W(2), .STALL_CYCLES(3)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lsu_ctrl_i(lsu_in),
    .ld_ready_i(ld_ready), .st_ready_i(st_ready), .lsu_ctrl_o(lsu_out2),
    .ld_valid_o(ld_valid2), .st_valid_o(st_valid2), .pop_ld_o(pop_ld2),
    .pop_st_o(pop_st2), .stall_o(stall2), .ld_cnt_o(ld_cnt2), .st_cnt_o(st_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, check the combinational pops
  // and scoreboard any unit accept, then advance to the next negedge.
  task automatic step(input logic v, input fu_t fu, input logic [2:0] tid,
                      input logic ldr, input logic str, input logic fl,
                      input logic exp_pld, input logic exp_pst);
    sb_t e;
    lsu_in          = '0;
    lsu_in.valid    = v;
    lsu_in.fu       = fu;
    lsu_in.trans_id = tid;
    lsu_in.vaddr    = {61'h1000, tid};
    ld_ready = ldr;
    st_ready = str;
    flush    = fl;
    #1;
    chk("pop_ld", pop_ld, exp_pld);
    chk("pop_st", pop_st, exp_pst);
    chk("pop_excl", pop_ld & pop_st, 0);
    if ((ld_valid && ld_ready) || (st_valid && st_ready)) begin
      if (sb_q.size() == 0) chk("sb_unexpected_accept", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("sb_class", ld_valid, e.is_ld);
        chk("sb_tid", lsu_out.trans_id, e.tid);
      end
    end
    if (exp_pld || exp_pst) sb_q.push_back('{is_ld: exp_pld, tid: tid});
    @(negedge clk);
  endtask

  task automatic idle(input logic ldr, input logic str);
    step(1'b0, NONE, 3'd0, ldr, str, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; ld_ready = 1'b0; st_ready = 1'b0; lsu_in = '0;
    #2;
    do_reset();
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_out_valid", lsu_out.valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ld_cnt", ld_cnt, 0);
    chk("rst_st_cnt", st_cnt, 0);

    // Single load, one-cycle latency, counted once accepted.
    step(1'b1, LOAD, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s1_ld_valid", ld_valid, 1);
    chk("s1_st_valid", st_valid, 0);
    chk("s1_tid", lsu_out.trans_id, 3);
    chk("s1_out_valid", lsu_out.valid, 1);
    idle(1'b1, 1'b0);
    chk("s1_empty", lsu_out.valid, 0);
    chk("s1_ld_cnt", ld_cnt, 1);

    // Back-to-back LD/ST/LD stream.
    step(1'b1, LOAD, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s2_ld1_valid", ld_valid, 1);
    step(1'b1, STORE, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s2_st_valid", st_valid, 1);
    chk("s2_st_tid", lsu_out.trans_id, 2);
    step(1'b1, LOAD, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s2_ld2_valid", ld_valid, 1);
    chk("s2_ld2_tid", lsu_out.trans_id, 4);
    idle(1'b1, 1'b1);
    chk("s2_empty", ld_valid | st_valid, 0);
    chk("s2_ld_cnt", ld_cnt, 3);
    chk("s2_st_cnt", st_cnt, 1);

    // Store held against st_ready=0; a waiting head must not be captured.
    step(1'b1, STORE, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, LOAD, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("s3_stall", stall, (i >= 3));
      chk("s3_hold_tid", lsu_out.trans_id, 5);
      chk("s3_st_valid", st_valid, 1);
    end
    idle(1'b0, 1'b1);
    chk("s3_stall_clr", stall, 0);
    chk("s3_st_cnt", st_cnt, 2);
    chk("s3_st_valid_off", st_valid, 0);

    // Flush while holding a load with a store waiting: no pop, nothing counted.
    step(1'b1, LOAD, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s4_ld_valid", ld_valid, 1);
    step(1'b1, STORE, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb_q.delete();
    chk("s4_ld_valid_off", ld_valid, 0);
    chk("s4_st_valid_off", st_valid, 0);
    chk("s4_out_valid", lsu_out.valid, 0);
    chk("s4_ld_cnt", ld_cnt, 3);
    chk("s4_st_cnt", st_cnt, 2);
    // An accept landing in the flush cycle is still counted.
    step(1'b1, LOAD, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, NONE, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sb_q.delete();
    chk("s4_flush_acc_cnt", ld_cnt, 4);
    chk("s4_flush_acc_empty", ld_valid, 0);

    // Saturation on the 2-bit instance.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, LOAD, 3'(k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("s5_sat_cnt", ld_cnt2, (k - 1 > 3) ? 3 : k - 1);
    end
    idle(1'b1, 1'b0);
    chk("s5_sat_final", ld_cnt2, 3);
    chk("s5_wide_cnt", ld_cnt, 5);

    // Asynchronous reset mid-hold, with a valid head still presented.
    step(1'b1, STORE, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_hold", st_valid, 1);
    lsu_in.valid = 1'b1;
    lsu_in.fu    = LOAD;
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_st_valid", st_valid, 0);
    chk("s6_out_valid", lsu_out.valid, 0);
    chk("s6_pop_ld", pop_ld, 0);
    chk("s6_pop_st", pop_st, 0);
    chk("s6_ld_cnt", ld_cnt, 0);
    chk("s6_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    idle(1'b0, 1'b0);
    chk("s6_post_empty", ld_valid | st_valid, 0);
    chk("s6_sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
